// File: rtl/glitch_err_collector.sv
// Glitch detector error collector: counts rising edges of per-channel error
// flags, keeps a saturating total, captures the first failing channel and
// raises a one-shot irq. A four-phase clr_req/clr_ack handshake wipes the record.
module glitch_err_collector #(
  parameter int unsigned NCH  = 8,
  parameter int unsigned CNTW = 8,
  parameter int unsigned TOTW = 16,
  localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dis,
  input  logic [NCH-1:0]  err_in,
  input  logic            clr_req,
  output logic            clr_ack,
  input  logic [SELW-1:0] rd_sel,
  output logic [CNTW-1:0] rd_cnt,
  output logic [TOTW-1:0] tot_cnt,
  output logic            err_any,
  output logic            first_vld,
  output logic [SELW-1:0] first_ch,
  output logic            irq
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StErr  = 2'd1;
  localparam logic [1:0] StClr  = 2'd2;
  localparam logic [1:0] StAck  = 2'd3;

  // Wide enough to add up to 32 simultaneous events without overflow.
  localparam int unsigned SUMW = TOTW + 6;
  localparam int unsigned RDN  = 2 ** SELW;

  localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};
  localparam logic [TOTW-1:0] TotMax = {TOTW{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [NCH-1:0]  err_q;
  logic [CNTW-1:0] cnt_q [NCH];
  logic [CNTW-1:0] cnt_d [NCH];
  logic [TOTW-1:0] tot_q, tot_d;
  logic            err_any_q, err_any_d;
  logic            first_vld_q, first_vld_d;
  logic [SELW-1:0] first_ch_q, first_ch_d;
  logic            irq_q, irq_d;
  logic [CNTW-1:0] rd_cnt_q;
  logic [CNTW-1:0] rd_tab [RDN];

  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  counted;
  logic            cnt_en;
  logic            any_ev;
  logic [5:0]      n_ev;
  logic [SELW-1:0] low_idx;
  logic [SUMW-1:0] tot_sum;

  // Event qualification: clear request pre-empts counting in IDLE/ERR.
  always_comb begin
    rise    = err_in & ~err_q;
    cnt_en  = ~dis & (state_q != StClr) &
              ~(clr_req & ((state_q == StIdle) | (state_q == StErr)));
    counted = rise & {NCH{cnt_en}};
    any_ev  = |counted;
  end

  // Popcount and lowest index of this cycle's counted events.
  always_comb begin
    n_ev    = '0;
    low_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      n_ev = n_ev + {5'd0, counted[i]};
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (counted[i]) low_idx = SELW'(i);
    end
  end

  // Handshake FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (clr_req) state_d = StClr;
        else if (any_ev) state_d = StErr;
      end
      StErr: begin
        if (clr_req) state_d = StClr;
      end
      StClr: state_d = StAck;
      StAck: begin
        if (!clr_req) state_d = (err_any_q | any_ev) ? StErr : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter, total and first-capture next state; CLR wipes everything.
  always_comb begin
    cnt_d       = cnt_q;
    tot_sum     = SUMW'(tot_q) + SUMW'(n_ev);
    tot_d       = (tot_sum > SUMW'(TotMax)) ? TotMax : tot_sum[TOTW-1:0];
    err_any_d   = err_any_q | any_ev;
    first_vld_d = first_vld_q | any_ev;
    first_ch_d  = first_ch_q;
    irq_d       = any_ev & ~first_vld_q;
    for (int i = 0; i < NCH; i++) begin
      if (counted[i] && (cnt_q[i] != CntMax)) cnt_d[i] = cnt_q[i] + 1'b1;
    end
    if (any_ev && !first_vld_q) first_ch_d = low_idx;
    if (state_q == StClr) begin
      for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
      tot_d       = '0;
      err_any_d   = 1'b0;
      first_vld_d = 1'b0;
      first_ch_d  = '0;
      irq_d       = 1'b0;
    end
  end

  // Readback table padded with zeros for unused select codes.
  always_comb begin
    for (int i = 0; i < RDN; i++) begin
      rd_tab[i] = '0;
      if (i < NCH) rd_tab[i] = cnt_q[i];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      err_q       <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      tot_q       <= '0;
      err_any_q   <= 1'b0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
      irq_q       <= 1'b0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_in;
      cnt_q       <= cnt_d;
      tot_q       <= tot_d;
      err_any_q   <= err_any_d;
      first_vld_q <= first_vld_d;
      first_ch_q  <= first_ch_d;
      irq_q       <= irq_d;
      rd_cnt_q    <= rd_tab[rd_sel];
    end
  end

  assign clr_ack   = (state_q == StAck);
  assign rd_cnt    = rd_cnt_q;
  assign tot_cnt   = tot_q;
  assign err_any   = err_any_q;
  assign first_vld = first_vld_q;
  assign first_ch  = first_ch_q;
  assign irq       = irq_q;

endmodule
